// File: rtl/fft4_stream_if.sv
// Sample/bin bus for fft4_stream: framed complex input samples and serial output bins.
interface fft4_stream_if;
  logic [31:0] A_real;
  logic [31:0] A_img;
  logic        start4;
  logic        end4;
  logic [31:0] out_real4;
  logic [31:0] out_img4;

  modport master (output A_real, A_img, start4, end4, input out_real4, out_img4);
  modport slave  (input A_real, A_img, start4, end4, output out_real4, out_img4);
endinterface

// File: rtl/fft4_stream.sv
// Streaming 4-point DFT: captures a framed group of 4 complex samples, emits X0..X3 serially.
// Optional macro FFT4_SCALE_EN: divide each bin by 4 (floor) before truncating to 32 bits.
module fft4_stream (
  input  logic          clk,
  input  logic          rst,
  fft4_stream_if.slave  io
);
  localparam int STAGES = 3;

  typedef enum logic [1:0] {IDLE, CAP1, CAP2, CAP3} state_t;

  state_t state, state_nxt;
  logic   cap_a, cap_b, cap_c, load;

  logic [2:0][31:0]     smp_re, smp_im;
  logic [3:0][31:0]     bin_re, bin_im, bin_re_nxt, bin_im_nxt;
  logic [STAGES:0]      vld_pipe;
  logic [31:0]          sel_re, sel_im;
  logic signed [33:0]   ar, ai, br, bi, cr, ci, dr, di;
  logic signed [33:0]   s_ac_r, s_ac_i, d_ac_r, d_ac_i, s_bd_r, s_bd_i, d_bd_r, d_bd_i;
  logic signed [33:0]   full_re [4];
  logic signed [33:0]   full_im [4];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // start4 restarts capture from any state and takes priority over end4
  always_comb begin
    state_nxt = state;
    cap_a     = 1'b0;
    cap_b     = 1'b0;
    cap_c     = 1'b0;
    load      = 1'b0;
    if (io.start4) begin
      cap_a     = 1'b1;
      state_nxt = CAP1;
    end else begin
      case (state)
        CAP1:    begin cap_b = 1'b1; state_nxt = CAP2; end
        CAP2:    begin cap_c = 1'b1; state_nxt = CAP3; end
        CAP3:    begin load = io.end4; state_nxt = IDLE; end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // d is never stored: it is the live input on the cycle that loads the buffer
  assign ar = {{2{smp_re[0][31]}}, smp_re[0]};
  assign ai = {{2{smp_im[0][31]}}, smp_im[0]};
  assign br = {{2{smp_re[1][31]}}, smp_re[1]};
  assign bi = {{2{smp_im[1][31]}}, smp_im[1]};
  assign cr = {{2{smp_re[2][31]}}, smp_re[2]};
  assign ci = {{2{smp_im[2][31]}}, smp_im[2]};
  assign dr = {{2{io.A_real[31]}}, io.A_real};
  assign di = {{2{io.A_img[31]}},  io.A_img};

  assign s_ac_r = ar + cr;
  assign s_ac_i = ai + ci;
  assign d_ac_r = ar - cr;
  assign d_ac_i = ai - ci;
  assign s_bd_r = br + dr;
  assign s_bd_i = bi + di;
  assign d_bd_r = br - dr;
  assign d_bd_i = bi - di;

  // -j*(x+jy) = y - jx, +j*(x+jy) = -y + jx
  assign full_re[0] = s_ac_r + s_bd_r;
  assign full_im[0] = s_ac_i + s_bd_i;
  assign full_re[1] = d_ac_r + d_bd_i;
  assign full_im[1] = d_ac_i - d_bd_r;
  assign full_re[2] = s_ac_r - s_bd_r;
  assign full_im[2] = s_ac_i - s_bd_i;
  assign full_re[3] = d_ac_r - d_bd_i;
  assign full_im[3] = d_ac_i + d_bd_r;

  for (genvar i = 0; i < 4; i++) begin : g_red
`ifdef FFT4_SCALE_EN
    assign bin_re_nxt[i] = 32'(full_re[i] >>> 2);
    assign bin_im_nxt[i] = 32'(full_im[i] >>> 2);
`else
    assign bin_re_nxt[i] = 32'(full_re[i]);
    assign bin_im_nxt[i] = 32'(full_im[i]);
`endif
  end

  // vld_pipe is one-hot on the bin emitted at the next edge
  always_comb begin
    sel_re = '0;
    sel_im = '0;
    for (int i = 0; i <= STAGES; i++) begin
      if (vld_pipe[i]) begin
        sel_re = bin_re[i];
        sel_im = bin_im[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      smp_re       <= '0;
      smp_im       <= '0;
      bin_re       <= '0;
      bin_im       <= '0;
      vld_pipe     <= '0;
      io.out_real4 <= '0;
      io.out_img4  <= '0;
    end else begin
      if (cap_a) begin smp_re[0] <= io.A_real; smp_im[0] <= io.A_img; end
      if (cap_b) begin smp_re[1] <= io.A_real; smp_im[1] <= io.A_img; end
      if (cap_c) begin smp_re[2] <= io.A_real; smp_im[2] <= io.A_img; end
      if (load) begin
        bin_re <= bin_re_nxt;
        bin_im <= bin_im_nxt;
      end
      vld_pipe     <= load ? {{STAGES{1'b0}}, 1'b1} : {vld_pipe[STAGES-1:0], 1'b0};
      io.out_real4 <= sel_re;
      io.out_img4  <= sel_im;
    end
  end
endmodule

// File: tb/tb_fft4_stream.sv
// Bench for fft4_stream: directed test-plan frames plus random framed traffic vs a DFT model.
module tb_fft4_stream;
  logic clk = 1'b0;
  logic rst;
  fft4_stream_if bus ();
  fft4_stream dut (.clk(clk), .rst(rst), .io(bus));

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [63:0] pend [$];
  int          pos;
  logic [31:0] sr [3];
  logic [31:0] si [3];
  logic [31:0] exp_re, exp_im;
  logic [31:0] o_re [16];
  logic [31:0] o_im [16];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] red(input longint v);
    longint t;
    t = v;
`ifdef FFT4_SCALE_EN
    t = t >>> 2;
`endif
    return t[31:0];
  endfunction

  // Direct DFT with W = -j: term n of bin k is rotated by (-j)^(n*k)
  task automatic model_frame(input logic [31:0] d_re, input logic [31:0] d_im);
    longint xr [4];
    longint xi [4];
    longint accr, acci;
    for (int n = 0; n < 3; n++) begin
      xr[n] = longint'($signed(sr[n]));
      xi[n] = longint'($signed(si[n]));
    end
    xr[3] = longint'($signed(d_re));
    xi[3] = longint'($signed(d_im));
    pend.delete();
    for (int k = 0; k < 4; k++) begin
      accr = 0;
      acci = 0;
      for (int n = 0; n < 4; n++) begin
        case ((n * k) % 4)
          0: begin accr += xr[n]; acci += xi[n]; end
          1: begin accr += xi[n]; acci -= xr[n]; end
          2: begin accr -= xr[n]; acci -= xi[n]; end
          default: begin accr -= xi[n]; acci += xr[n]; end
        endcase
      end
      pend.push_back({red(accr), red(acci)});
    end
  endtask

  task automatic model_edge(input logic [31:0] re, input logic [31:0] im,
                            input logic s, input logic e, input logic r);
    if (r) begin
      pend.delete();
      pos    = 0;
      exp_re = '0;
      exp_im = '0;
    end else begin
      if (pend.size() > 0) {exp_re, exp_im} = pend.pop_front();
      else begin exp_re = '0; exp_im = '0; end
      if (s) begin
        sr[0] = re; si[0] = im; pos = 1;
      end else if (pos == 1 || pos == 2) begin
        sr[pos] = re; si[pos] = im; pos++;
      end else if (pos == 3) begin
        if (e) model_frame(re, im);
        pos = 0;
      end
    end
  endtask

  task automatic cycle(input logic [31:0] re, input logic [31:0] im, input logic s,
                       input logic e, input logic r,
                       output logic [31:0] gr, output logic [31:0] gi);
    bus.A_real = re;
    bus.A_img  = im;
    bus.start4 = s;
    bus.end4   = e;
    rst        = r;
    @(posedge clk);
    model_edge(re, im, s, e, r);
    #1;
    gr = bus.out_real4;
    gi = bus.out_img4;
    chk("out_re", gr, exp_re);
    chk("out_im", gi, exp_im);
  endtask

  task automatic idle(input int n, input int base);
    for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, 0, o_re[base+k], o_im[base+k]);
  endtask

  task automatic ramp(input int base, input logic up);
    for (int i = 0; i < 4; i++)
      cycle(up ? 32'(i + 1) : 32'(4 - i), 0, i == 0, i == 3, 0, o_re[base+i], o_im[base+i]);
  endtask

  initial begin
    int er [8];
    int ei [8];
    logic [31:0] gr, gi;
    logic        s, e, r;
    logic [31:0] vr, vi;
    pos = 0; exp_re = '0; exp_im = '0;

    cycle(32'h1234, 32'h5678, 1, 0, 1, gr, gi);
    cycle(32'h1234, 32'h5678, 0, 0, 1, gr, gi);
    chk("rst_re", gr, 0);
    chk("rst_im", gi, 0);

    // ramp frame, bins one cycle after end4 then zero
`ifdef FFT4_SCALE_EN
    er = '{2, -1, -1, -1, 0, 0, 0, 0}; ei = '{0, 0, 0, -1, 0, 0, 0, 0};
`else
    er = '{10, -2, -2, -2, 0, 0, 0, 0}; ei = '{0, 2, 0, -2, 0, 0, 0, 0};
`endif
    ramp(0, 1);
    chk("ramp_lat", o_re[3], 0);
    idle(5, 0);
    for (int k = 0; k < 5; k++) begin
      chk("ramp_re", o_re[k], 32'(er[k]));
      chk("ramp_im", o_im[k], 32'(ei[k]));
    end

    // impulse
    cycle(100, 50, 1, 0, 0, gr, gi);
    for (int i = 1; i < 4; i++) cycle(0, 0, 0, i == 3, 0, gr, gi);
    idle(5, 0);
    for (int k = 0; k < 4; k++) begin
`ifdef FFT4_SCALE_EN
      chk("imp_re", o_re[k], 25); chk("imp_im", o_im[k], 12);
`else
      chk("imp_re", o_re[k], 100); chk("imp_im", o_im[k], 50);
`endif
    end
    chk("imp_tail", o_re[4], 0);

    // wrap / scale of full-scale real input
    for (int i = 0; i < 4; i++) cycle(32'h7FFFFFFF, 0, i == 0, i == 3, 0, gr, gi);
    idle(4, 0);
`ifdef FFT4_SCALE_EN
    chk("wrap_x0", o_re[0], 32'h7FFFFFFF);
`else
    chk("wrap_x0", o_re[0], 32'hFFFFFFFC);
`endif
    for (int k = 1; k < 4; k++) chk("wrap_xk", o_re[k], 0);

    // back-to-back frames stream without idle gaps
`ifdef FFT4_SCALE_EN
    er = '{2, -1, -1, -1, 2, 0, 0, 0}; ei = '{0, 0, 0, -1, 0, -1, 0, 0};
`else
    er = '{10, -2, -2, -2, 10, 2, 2, 2}; ei = '{0, 2, 0, -2, 0, -2, 0, 2};
`endif
    ramp(0, 1);
    ramp(4, 0);
    idle(4, 8);
    for (int k = 0; k < 8; k++) begin
      chk("b2b_re", o_re[4+k], 32'(er[k]));
      chk("b2b_im", o_im[4+k], 32'(ei[k]));
    end

    // missing end4, then a restart in CAP2 followed by a valid frame
    for (int i = 0; i < 4; i++) cycle(32'(i + 1), 0, i == 0, 0, 0, gr, gi);
    idle(4, 0);
    for (int k = 0; k < 4; k++) chk("noend", o_re[k], 0);
    cycle(9, 9, 1, 0, 0, gr, gi);
    cycle(9, 9, 0, 0, 0, gr, gi);
    ramp(0, 1);
    idle(1, 0);
    chk("restart_x0", o_re[0], 32'(er[0]));

    // reset during X1 emission
    ramp(0, 1);
    idle(1, 0);
    cycle(0, 0, 0, 0, 1, gr, gi);
    chk("rst_mid_re", gr, 0);
    chk("rst_mid_im", gi, 0);
    idle(3, 0);
    for (int k = 0; k < 3; k++) chk("rst_quiet", o_re[k], 0);
    ramp(0, 1);
    idle(2, 0);
    chk("post_rst_x0", o_re[0], 32'(er[0]));
    chk("post_rst_x1", o_im[1], 32'(ei[1]));

    // random framed traffic with stray starts, dropped ends and rare resets
    for (int f = 0; f < 120; f++) begin
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) idle(1, 0);
      for (int n = 0; n < 4; n++) begin
        s  = (n == 0) || ($urandom_range(0, 19) == 0);
        e  = (n == 3) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 9) == 0);
        r  = ($urandom_range(0, 149) == 0);
        vr = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 63)) - 32;
        vi = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 63)) - 32;
        cycle(vr, vi, s, e, r, gr, gi);
      end
    end
    idle(6, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
